fp16_cvt_arbiter: RTL and testbench

- Shares one combinational `sign_ex` FP16->FP32 converter between NUM_REQ requesters.
- Requesters are arbitrated round-robin over valid/ready handshakes.
- The accepted FP16 operand is registered, converted, and presented on a registered FP32 output stream tagged with the requester id.
- Sits between FP16 producers (sensor/compute lanes) and an FP32 consumer.

---
 rtl/fp16_cvt_arbiter.sv | 145 ++++++++++++++
 tb/tb_fp16_cvt_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fp16_cvt_arbiter.sv
// Round-robin arbiter sharing one FP16->FP32 converter across NUM_REQ requesters.
// Optional FP16_CLASS_EN adds out_class (zero/normal, subnormal, inf, NaN).
module fp16_cvt_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*16-1:0]   req_fp16,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_fp32,
    output logic [ID_W-1:0]         out_id,
`ifdef FP16_CLASS_EN
    output logic [1:0]              out_class,
`endif
    output logic                    busy
);

    typedef enum logic [1:0] {StIdle, StConv, StOut} state_e;

    state_e            r_state, w_state_next;
    logic [ID_W-1:0]   r_rr_ptr, r_id, w_grant_id, w_ptr_next;
    logic              w_grant_vld;
    logic [15:0]       r_operand;
    logic              r_out_valid;
    logic [31:0]       r_out_fp32, w_fp32;
    logic [ID_W-1:0]   r_out_id;
    logic              w_sign;
    logic [4:0]        w_exp16;
    logic [9:0]        w_man16, w_sub_man;
    logic [3:0]        w_lead;

    // Rotating priority: lowest offset from r_rr_ptr wins, so iterate from the far end.
    always_comb begin
        logic [ID_W:0] w_idx;
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(NUM_REQ)) w_idx = w_idx - (ID_W+1)'(NUM_REQ);
            if (req_valid[w_idx[ID_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_idx[ID_W-1:0];
            end
        end
        w_ptr_next = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
    end

    assign w_sign  = r_operand[15];
    assign w_exp16 = r_operand[14:10];
    assign w_man16 = r_operand[9:0];

    always_comb begin : sign_ex
        w_lead = '0;
        for (int i = 0; i < 10; i++) begin
            if (w_man16[i]) w_lead = 4'(i);
        end
        // Subnormal: shift the leading one out past bit 9 to form the hidden bit.
        w_sub_man = w_man16 << (4'd10 - w_lead);
        w_fp32    = {w_sign, 31'b0};
        if (w_exp16 == 5'h1F) begin
            w_fp32 = {w_sign, 8'hFF, w_man16, 13'b0};
        end else if (w_exp16 != 5'h00) begin
            w_fp32 = {w_sign, 8'(w_exp16) + 8'd112, w_man16, 13'b0};
        end else if (w_man16 != 10'h000) begin
            w_fp32 = {w_sign, 8'd103 + 8'(w_lead), w_sub_man, 13'b0};
        end
    end

`ifdef FP16_CLASS_EN
    logic [1:0] r_out_class, w_class;

    always_comb begin
        w_class = 2'b00;
        if (w_exp16 == 5'h1F) w_class = (w_man16 != 10'h000) ? 2'b11 : 2'b10;
        else if (w_exp16 == 5'h00 && w_man16 != 10'h000) w_class = 2'b01;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_out_class <= 2'b00;
        else if (r_state == StConv) r_out_class <= w_class;
    end

    assign out_class = r_out_class;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_grant_vld) w_state_next = StConv;
            StConv:  w_state_next = StOut;
            StOut:   if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (r_state == StIdle && w_grant_vld) req_ready[w_grant_id] = 1'b1;
        busy = (r_state != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_operand   <= 16'h0000;
            r_out_valid <= 1'b0;
            r_out_fp32  <= 32'h0000_0000;
            r_out_id    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_grant_vld) begin
                        r_operand <= req_fp16[16*w_grant_id +: 16];
                        r_id      <= w_grant_id;
                        r_rr_ptr  <= w_ptr_next;
                    end
                end
                StConv: begin
                    r_out_fp32  <= w_fp32;
                    r_out_id    <= r_id;
                    r_out_valid <= 1'b1;
                end
                StOut: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_fp32  = r_out_fp32;
    assign out_id    = r_out_id;

endmodule

// File: tb/tb_fp16_cvt_arbiter.sv
// Directed self-checking bench for fp16_cvt_arbiter (NUM_REQ=4).
// Define FP16_CLASS_EN to also exercise out_class.
module tb_fp16_cvt_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_fp16;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_fp32;
    logic [1:0]  out_id;
    logic        busy;
`ifdef FP16_CLASS_EN
    logic [1:0]  out_class;
`endif

    int errors = 0;
    int checks = 0;

    fp16_cvt_arbiter #(.NUM_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_fp16  (req_fp16),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp32  (out_fp32),
        .out_id    (out_id),
`ifdef FP16_CLASS_EN
        .out_class (out_class),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req_fp16 = 64'h0;
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_fp32 !== 32'h0) begin errors++; $display("FAIL rst_out_fp32: got %h expected 00000000", out_fp32); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL rst_out_id: got %0d expected 0", out_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
        // Accept an operand, then reset while it is being converted.
        req_fp16[15:0] = 16'h4380;
        req_valid = 4'b0001;
        out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_grant: got %b expected 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_conv: got %b expected 1", busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_out: got %b expected 0 (cycle %0d)", out_valid, c); end
            tick();
        end
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_ptr0: got %b expected 0001", req_ready); end
        req_valid = 4'b0000;
        #1;
    endtask

    task automatic test_single();
        req_fp16  = 64'h0;
        req_fp16[15:0] = 16'h4380;
        out_ready = 1'b1;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_conv: got %b expected 0000", req_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        checks++; if (out_fp32 !== 32'h4070_0000) begin errors++; $display("FAIL single_fp32: got %h expected 40700000", out_fp32); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d expected 0", out_id); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got %b expected 0", out_valid); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_fp [5] = '{32'h0000_0000, 32'h4070_0000, 32'hC0D0_0000,
                                    32'h3F80_0000, 32'h0000_0000};
        int n = 0;
        int multi = 0;
        do_reset();
        req_fp16  = {16'h3C00, 16'hC680, 16'h4380, 16'h0000};
        out_ready = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 40 && n < 5; c++) begin
            tick();
            if ($countones(req_ready) > 1) multi++;
            if (out_valid === 1'b1) begin
                checks++; if (out_id !== 2'(n % 4)) begin errors++; $display("FAIL rr_id[%0d]: got %0d expected %0d", n, out_id, n % 4); end
                checks++; if (out_fp32 !== exp_fp[n]) begin errors++; $display("FAIL rr_fp32[%0d]: got %h expected %h", n, out_fp32, exp_fp[n]); end
                n++;
            end
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL rr_timeout: got %0d results expected 5", n); end
        checks++; if (multi !== 0) begin errors++; $display("FAIL rr_onehot: got %0d multi-grant cycles expected 0", multi); end
        req_valid = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        req_fp16  = {16'h3C00, 16'hC680, 16'h4380, 16'h0000};
        out_ready = 1'b0;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant: got %b expected 0100", req_ready); end
        tick();
        req_valid = 4'b1111;
        tick();
        checks++; if (out_valid !== 1'b1 || out_fp32 !== 32'hC0D0_0000 || out_id !== 2'd2) begin
            errors++; $display("FAIL bp_first: got v=%b %h id=%0d expected v=1 c0d00000 id=2", out_valid, out_fp32, out_id);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_fp32 !== 32'hC0D0_0000 || out_id !== 2'd2) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%b %h id=%0d expected v=1 c0d00000 id=2", c, out_valid, out_fp32, out_id);
            end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", c, req_ready); end
        end
        out_ready = 1'b1;
        req_valid = 4'b0000;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b expected 0", busy); end
    endtask

    // Follows test_backpressure: id2 was last granted, so the pointer sits at 3.
    task automatic test_wrap_skip();
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_grant: got %b expected 0010", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_fp32 !== 32'h4070_0000) begin
            errors++; $display("FAIL wrap_out: got v=%b %h id=%0d expected v=1 40700000 id=1", out_valid, out_fp32, out_id);
        end
        tick();
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_ptr2: got %b expected 0100", req_ready); end
        req_valid = 4'b0000;
        #1;
    endtask

`ifdef FP16_CLASS_EN
    task automatic test_class();
        logic [15:0] ops [4] = '{16'h7C00, 16'h7E00, 16'h0001, 16'h3C00};
        logic [1:0]  cls [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        logic [31:0] fps [4] = '{32'h7F80_0000, 32'h7FC0_0000, 32'h3380_0000, 32'h3F80_0000};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_fp16[15:0] = ops[k];
            req_valid = 4'b0001;
            tick();
            req_valid = 4'b0000;
            tick();
            checks++; if (out_valid !== 1'b1 || out_class !== cls[k]) begin
                errors++; $display("FAIL class[%0d]: got v=%b cls=%b expected v=1 cls=%b", k, out_valid, out_class, cls[k]);
            end
            checks++; if (out_fp32 !== fps[k]) begin errors++; $display("FAIL class_fp32[%0d]: got %h expected %h", k, out_fp32, fps[k]); end
            tick();
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap_skip();
`ifdef FP16_CLASS_EN
        test_class();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
